// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII control codes, default clocking and the TX FIFO state type.
package uart_pkg;
  localparam int unsigned CLK_FREQ  = 100_000_000;
  localparam int unsigned BAUD_RATE = 115200;
  localparam logic [7:0]  ASCII_CR  = 8'h0D;
  localparam logic [7:0]  ASCII_LF  = 8'h0A;

  typedef enum logic {PASS, LF_HOLD} fifo_state_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake and status bundle between the MMIO side, the TX FIFO and the transmitter.
interface uart_tx_fifo_if #(parameter int DEPTH = 16);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready;
  logic [PTR_W:0] count;
  logic           empty;
  logic           full;
  logic           overflow;
  logic           clr_overflow;

  modport master (
    output in_data, in_valid, out_ready, clr_overflow,
    input  in_ready, out_data, out_valid, count, empty, full, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready, clr_overflow,
    output in_ready, out_data, out_valid, count, empty, full, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Generic DEPTH x 8 first-word-fall-through FIFO; pointers carry one extra wrap bit.
module sync_fifo #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [7:0]     wr_data,
  input  logic           rd_en,
  output logic [7:0]     rd_data,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           empty
);
  logic [7:0]     mem [DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;

  // Storage is cleared on reset so the head byte reads 8'h00 when empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (wr_en && !full) begin
        mem[wr_ptr[PTR_W-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (rd_en && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[PTR_W-1:0]];
endmodule

// File: rtl/uart_tx_fifo.sv
// UART TX byte buffer: FWFT FIFO plus sticky overflow and optional LF -> CR LF expansion
// (enabled by defining UART_TX_FIFO_CRLF_EN).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]     head;
  logic           rd_en;
  logic           full, empty;
  logic [PTR_W:0] count;
  logic           overflow;
  logic           hs;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.in_valid),
    .wr_data (bus.in_data),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign hs = !empty && bus.out_ready;

`ifdef UART_TX_FIFO_CRLF_EN
  fifo_state_t state;
  logic        ins_cr;

  // A head LF is first presented as CR without being consumed.
  assign ins_cr       = (state == PASS) && !empty && (head == ASCII_LF);
  assign bus.out_data = ins_cr ? ASCII_CR : head;
  assign rd_en        = hs && !ins_cr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= PASS;
    else if (hs) state <= ins_cr ? LF_HOLD : PASS;
  end
`else
  assign bus.out_data = head;
  assign rd_en        = hs;
`endif

  // A dropped write wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    overflow <= 1'b0;
    else if (bus.in_valid && full) overflow <= 1'b1;
    else if (bus.clr_overflow)     overflow <= 1'b0;
  end

  assign bus.out_valid = !empty;
  assign bus.in_ready  = !full;
  assign bus.count     = count;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected output bytes are queued on push, compared on pop.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
`ifdef UART_TX_FIFO_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         ins;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) ifc ();
  uart_tx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  exp_t exp_q[$];
  int   mcount = 0;
  bit   movf = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check outputs at negedge, advance the model, drive the next inputs.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    bit was_full;
    exp_t e;
    @(negedge clk);
    check("count", 32'(ifc.count), 32'(mcount));
    check("out_valid", 32'(ifc.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_data", 32'(ifc.out_data), 32'(exp_q[0].data));
    check("full", 32'(ifc.full), 32'(mcount == DEPTH));
    check("empty", 32'(ifc.empty), 32'(mcount == 0));
    check("in_ready", 32'(ifc.in_ready), 32'(mcount != DEPTH));
    check("overflow", 32'(ifc.overflow), 32'(movf));
    check("count_max", 32'(ifc.count <= DEPTH), 32'd1);
    was_full = (mcount == DEPTH);
    if (ordy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (!e.ins) mcount--;
    end
    if (iv) begin
      if (!was_full) begin
        if (CRLF && d == 8'h0A) exp_q.push_back('{8'h0D, 1'b1});
        exp_q.push_back('{d, 1'b0});
        mcount++;
      end else movf = 1'b1;
    end
    if (!(iv && was_full) && clr) movf = 1'b0;
    ifc.in_valid     = iv;
    ifc.in_data      = d;
    ifc.out_ready    = ordy;
    ifc.clr_overflow = clr;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    ifc.in_valid = 1'b0; ifc.in_data = 8'h00; ifc.out_ready = 1'b0; ifc.clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_data", 32'(ifc.out_data), 32'h00);
    rst_n = 1'b1;

    // Single byte, long backpressure
    step(1'b1, 8'h41, 1'b0, 1'b0);
    repeat (1000) step(1'b0, 8'h00, 1'b0, 1'b0);
    drain("drain_single");

    // Fill, overflow, drain, clear
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain("drain_full");
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random stream with pointer wrap
    sent = 0; cyc = 0;
    while ((sent < 40 || exp_q.size() != 0) && cyc < 3000) begin
      logic iv;
      iv = (sent < 40) && (mcount < DEPTH - 1) && ($urandom_range(0, 1) == 1);
      step(iv, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      if (iv) sent++;
      cyc++;
    end
    check("stream_done", 32'(cyc < 3000), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous push/pop at count 5, then overflow vs clear
    for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h30, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("push_pop_count", 32'(ifc.count), 32'd5);
    for (int i = 0; i < 11; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_beats_clr", 32'(ifc.overflow), 32'd1);

    // Reset mid-stream at count 7 with overflow set
    repeat (9) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_count", 32'(ifc.count), 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_empty", 32'(ifc.empty), 32'd1);
    check("rst_count", 32'(ifc.count), 32'd0);
    check("rst_overflow", 32'(ifc.overflow), 32'd0);
    exp_q.delete(); mcount = 0; movf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_data", 32'(ifc.out_data), 32'h55);
    drain("drain_rst");

    // LF handling (expanded to CR LF only when the feature is built in)
    step(1'b1, 8'h48, 1'b0, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h49, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("lf_head_data", 32'(ifc.out_data), CRLF ? 32'h0D : 32'h0A);
    check("lf_head_count", 32'(ifc.count), 32'd2);
    drain("drain_lf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
